// File: rtl/instr_sequencer_if.sv
// CPU-side handshake bundle between the instruction sequencer and the cpu block.
// The master side drives the instruction and the load/start strobes, and the slave side returns the wait flag.
interface instr_sequencer_if;
   logic [15:0] cpu_in;
   logic        cpu_load;
   logic        cpu_s;
   logic        cpu_w;

   modport master (output cpu_in, output cpu_load, output cpu_s, input cpu_w);
   modport slave  (input cpu_in, input cpu_load, input cpu_s, output cpu_w);
endinterface

// File: rtl/instr_sequencer.sv
// Steps through a small writable program memory and feeds each instruction to the cpu.
// Each instruction follows load, then start, then a wait on the cpu's w handshake.
module instr_sequencer #(
   parameter int unsigned AW      = 4,
   parameter int unsigned TIMEOUT = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 prog_we,
   input  logic [AW-1:0]        prog_addr,
   input  logic [15:0]          prog_data,
   input  logic                 run,
   input  logic [AW:0]          len,
   instr_sequencer_if.master    cpu,
   output logic [AW-1:0]        pc,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 1 << AW;
   localparam int unsigned CW    = $clog2(TIMEOUT) + 1;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_START     = 3'd2,
      S_WAIT_BUSY = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_NEXT      = 3'd5,
      S_DONE      = 3'd6
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   pc_q, pc_d;
   logic [DW-1:0]   cpu_in_q, cpu_in_d;
   logic            err_q, err_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   mem_q [DEPTH];

   logic [AW-1:0]   pc_next;
   logic            last_instr;
   logic            load_c, start_c, busy_c, done_c;

   assign pc_next    = pc_q + AW'(1);
   assign last_instr = ((AW+1)'({1'b0, pc_q}) + (AW+1)'(1)) == len;

   // Program memory: writable only while idle, never cleared by reset
   always_ff @(posedge clk) begin
      if (prog_we && (state_q == S_IDLE)) begin
         mem_q[prog_addr] <= prog_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         cpu_in_q <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         cpu_in_q <= cpu_in_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      cpu_in_d = cpu_in_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (run) begin
               err_d = 1'b0;
               pc_d  = '0;
               if (len != '0) begin
                  state_d  = S_LOAD;
                  cpu_in_d = mem_q[0];
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_LOAD:  state_d = S_START;
         S_START: begin
            cnt_d   = '0;
            state_d = S_WAIT_BUSY;
         end
         // Only the start of execution is timed; the run length of an instruction is unbounded
         S_WAIT_BUSY: begin
            if (!cpu.cpu_w) begin
               state_d = S_WAIT_DONE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WAIT_DONE: begin
            if (cpu.cpu_w) state_d = S_NEXT;
         end
         S_NEXT: begin
            if (last_instr) begin
               state_d = S_DONE;
            end else begin
               pc_d     = pc_next;
               cpu_in_d = mem_q[pc_next];
               state_d  = S_LOAD;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes decode from the state flop alone, so reset drops them at once
   always_comb begin
      load_c  = 1'b0;
      start_c = 1'b0;
      done_c  = 1'b0;
      busy_c  = (state_q != S_IDLE);
      unique case (state_q)
         S_LOAD:  load_c  = 1'b1;
         S_START: start_c = 1'b1;
         S_DONE:  done_c  = 1'b1;
         default: ;
      endcase
   end

   assign cpu.cpu_in   = cpu_in_q;
   assign cpu.cpu_load = load_c;
   assign cpu.cpu_s    = start_c;
   assign pc           = pc_q;
   assign busy         = busy_c;
   assign done         = done_c;
   assign err          = err_q;

endmodule
